// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode, ALU and forwarding encodings shared by the MIPS pipeline control path
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_SUB  = 6'h22;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;

    // One-bit control fields produced in ID; uses_rt marks instructions that read rt as a source.
    typedef struct packed {
        logic alu_src;
        logic r_data;
        logic w_data;
        logic mem_to_reg;
        logic w_reg;
        logic branch;
        logic uses_rt;
        logic illegal;
    } ctrl_t;
endpackage

// File: rtl/mips_decoder.sv
// rtl/mips_decoder.sv - combinational ID-stage decode of op/funct into the control bundle
module mips_decoder
    import mips_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 6
) (
    input  logic [OP_W-1:0]     op_i,
    input  logic [OP_W-1:0]     funct_i,
    input  logic [REG_AW-1:0]   rt_i,
    input  logic [REG_AW-1:0]   rd_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [REG_AW-1:0]   dst_o,
    output ctrl_t               ctrl_o
);
    always_comb begin
        alu_op_o = '0;
        dst_o    = '0;
        ctrl_o   = '0;
        case (op_i)
            OP_W'(OP_RTYPE): begin
                alu_op_o       = ALU_OP_W'(funct_i);
                dst_o          = rd_i;
                ctrl_o.w_reg   = 1'b1;
                ctrl_o.uses_rt = 1'b1;
            end
            OP_W'(OP_LW): begin
                alu_op_o          = ALU_OP_W'(ALU_ADD);
                dst_o             = rt_i;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.r_data     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.w_reg      = 1'b1;
            end
            OP_W'(OP_SW): begin
                alu_op_o       = ALU_OP_W'(ALU_ADD);
                ctrl_o.alu_src = 1'b1;
                ctrl_o.w_data  = 1'b1;
                ctrl_o.uses_rt = 1'b1;
            end
            OP_W'(OP_ADDI): begin
                alu_op_o       = ALU_OP_W'(ALU_ADD);
                dst_o          = rt_i;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.w_reg   = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                alu_op_o       = ALU_OP_W'(ALU_SUB);
                ctrl_o.branch  = 1'b1;
                ctrl_o.uses_rt = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
        // r0 is hardwired: a zero destination is never a writer, so it never forwards or stalls
        if (dst_o == '0) ctrl_o.w_reg = 1'b0;
    end
endmodule

// File: rtl/mips_pipe_ctrl.sv
// rtl/mips_pipe_ctrl.sv - pipelined EX/MEM/WB control with stall, flush and forwarding selection
module mips_pipe_ctrl
    import mips_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 6,
    parameter int CNT_W    = 16,
    parameter int FWD_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     op,
    input  logic [OP_W-1:0]     funct,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                zero,
    input  logic                dmem_ready,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic                branch_taken,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                r_data,
    output logic                w_data,
    output logic                w_reg,
    output logic [REG_AW-1:0]   wb_dst,
    output logic                mem_to_reg,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    stall_cnt
);
    typedef struct packed {
        logic                valid;
        logic                alu_src;
        logic                r_data;
        logic                w_data;
        logic                mem_to_reg;
        logic                w_reg;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_AW-1:0]   dst;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
    } ex_t;

    typedef struct packed {
        logic              valid;
        logic              r_data;
        logic              w_data;
        logic              mem_to_reg;
        logic              w_reg;
        logic [REG_AW-1:0] dst;
    } mem_t;

    typedef struct packed {
        logic              valid;
        logic              mem_to_reg;
        logic              w_reg;
        logic [REG_AW-1:0] dst;
    } wb_t;

    logic [ALU_OP_W-1:0] id_alu_op;
    logic [REG_AW-1:0]   id_dst;
    ctrl_t               id_ctrl;

    mips_decoder #(.OP_W(OP_W), .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W)) u_decoder (
        .op_i    (op),
        .funct_i (funct),
        .rt_i    (id_rt),
        .rd_i    (id_rd),
        .alu_op_o(id_alu_op),
        .dst_o   (id_dst),
        .ctrl_o  (id_ctrl)
    );

    ex_t              ex_q, ex_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic             wb_hold_q, wb_hold_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_stall, branch, ex_hit, mem_hit, hazard, data_stall;

    always_comb begin
        mem_stall  = mem_q.valid & (mem_q.r_data | mem_q.w_data) & ~dmem_ready;
        branch     = ex_q.valid & ex_q.branch & zero & ~mem_stall;
        ex_hit     = ex_q.valid & ex_q.w_reg &
                     ((ex_q.dst == id_rs) | ((ex_q.dst == id_rt) & id_ctrl.uses_rt));
        mem_hit    = mem_q.valid & mem_q.w_reg &
                     ((mem_q.dst == id_rs) | ((mem_q.dst == id_rt) & id_ctrl.uses_rt));
        hazard     = (FWD_EN != 0) ? (ex_hit & ex_q.r_data) : (ex_hit | mem_hit);
        data_stall = hazard & ~branch & ~mem_stall;
    end

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if ((FWD_EN != 0) && ex_q.valid) begin
            if (mem_q.valid & mem_q.w_reg & ~mem_q.r_data & (mem_q.dst == ex_q.rs)) fwd_a = FWD_MEM;
            else if (wb_q.valid & wb_q.w_reg & (wb_q.dst == ex_q.rs))               fwd_a = FWD_WB;
            if (mem_q.valid & mem_q.w_reg & ~mem_q.r_data & (mem_q.dst == ex_q.rt)) fwd_b = FWD_MEM;
            else if (wb_q.valid & wb_q.w_reg & (wb_q.dst == ex_q.rt))               fwd_b = FWD_WB;
        end
    end

    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        ill_d     = 1'b0;
        wb_hold_d = mem_stall;
        cnt_d     = cnt_q;
        if (!mem_stall) begin
            wb_d  = '{valid: mem_q.valid, mem_to_reg: mem_q.mem_to_reg, w_reg: mem_q.w_reg, dst: mem_q.dst};
            mem_d = '{valid: ex_q.valid, r_data: ex_q.r_data, w_data: ex_q.w_data,
                      mem_to_reg: ex_q.mem_to_reg, w_reg: ex_q.w_reg, dst: ex_q.dst};
            if (branch || data_stall) begin
                ex_d.valid = 1'b0;
            end else begin
                ex_d  = '{valid: ~id_ctrl.illegal, alu_src: id_ctrl.alu_src, r_data: id_ctrl.r_data,
                          w_data: id_ctrl.w_data, mem_to_reg: id_ctrl.mem_to_reg, w_reg: id_ctrl.w_reg,
                          branch: id_ctrl.branch, alu_op: id_alu_op, dst: id_dst, rs: id_rs, rt: id_rt};
                ill_d = id_ctrl.illegal;
            end
        end
        if (!pc_write && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            wb_hold_q <= 1'b0;
            ill_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            wb_hold_q <= wb_hold_d;
            ill_q     <= ill_d;
            cnt_q     <= cnt_d;
        end
    end

    // A WB entry held by a memory stall has already written once; suppress the repeat.
    assign pc_write     = ~(mem_stall | data_stall);
    assign ifid_write   = ~(mem_stall | data_stall);
    assign ifid_flush   = branch;
    assign branch_taken = branch;
    assign alu_op       = ex_q.valid ? ex_q.alu_op : '0;
    assign alu_src      = ex_q.valid & ex_q.alu_src;
    assign r_data       = mem_q.valid & mem_q.r_data;
    assign w_data       = mem_q.valid & mem_q.w_data;
    assign w_reg        = wb_q.valid & wb_q.w_reg & ~wb_hold_q;
    assign wb_dst       = wb_q.valid ? wb_q.dst : '0;
    assign mem_to_reg   = wb_q.valid & wb_q.mem_to_reg;
    assign illegal_op   = ill_q;
    assign stall_cnt    = cnt_q;
endmodule
